// File: rtl/secondary_input_receiver_pkg.sv
// Shared constants and FSM state type for the secondary-input word stream
// (receiver side; the sender uses the same encodings).
package secondary_input_receiver_pkg;

  localparam int DEFAULT_DATA_WIDTH  = 32;
  localparam int DEFAULT_DATA_LENGTH = 1024;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2
  } rx_state_t;

endpackage

// File: rtl/secondary_input_receiver_deser.sv
// MSW-first word deserializer: each accepted word enters at the bottom and
// pushes earlier words toward the top of the assembled operand.
module word_shift_deser #(
  parameter int DATA_WIDTH  = 32,
  parameter int DATA_LENGTH = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clr,
  input  logic                   shift_en,
  input  logic [DATA_WIDTH-1:0]  word_in,
  output logic [DATA_LENGTH-1:0] data_out
);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      data_out <= '0;
    end else if (shift_en) begin
      data_out <= {data_out[DATA_LENGTH-DATA_WIDTH-1:0], word_in};
    end
  end

endmodule

// File: rtl/secondary_input_receiver.sv
// Receive end of the secondary-input stream: assembles r and t from
// MSW-first word beats, latches n0p, and flags completion.
module secondary_input_receiver
  import secondary_input_receiver_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int DATA_LENGTH = DEFAULT_DATA_LENGTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start_transfer,
  input  logic                   word_valid,
  input  logic [DATA_WIDTH-1:0]  r_word,
  input  logic [DATA_WIDTH-1:0]  t_word,
  input  logic [DATA_WIDTH-1:0]  n0p,
  output logic [DATA_LENGTH-1:0] r_out,
  output logic [DATA_LENGTH-1:0] t_out,
  output logic [DATA_WIDTH-1:0]  n0p_out,
  output logic                   busy,
  output logic                   rt_valid,
  output logic                   done
);

  localparam int WORDS = DATA_LENGTH / DATA_WIDTH;
  localparam int CNT_W = $clog2(WORDS) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORDS - 1);

  rx_state_t        state, next_state;
  logic             start_q;
  logic             start_rise;
  logic [CNT_W-1:0] cnt;
  logic             clr;
  logic             shift_en;
  logic             last_beat;

  assign start_rise = start_transfer & ~start_q;
  assign busy       = (state == RECV);

  // A start edge outranks a beat in the same cycle, so the edge cycle never
  // captures a word and an abort in RECV cannot also complete the transfer.
  always_comb begin
    next_state = state;
    clr        = 1'b0;
    shift_en   = 1'b0;
    last_beat  = 1'b0;
    case (state)
      IDLE: begin
        if (start_rise) begin
          clr        = 1'b1;
          next_state = RECV;
        end
      end
      RECV: begin
        if (start_rise) begin
          clr = 1'b1;
        end else if (word_valid) begin
          shift_en = 1'b1;
          if (cnt == LAST_CNT) begin
            last_beat  = 1'b1;
            next_state = DONE;
          end
        end
      end
      DONE: begin
        if (start_rise) begin
          clr        = 1'b1;
          next_state = RECV;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      start_q <= 1'b0;
    end else begin
      state   <= next_state;
      start_q <= start_transfer;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      n0p_out  <= '0;
      rt_valid <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= last_beat;
      if (clr) begin
        cnt      <= '0;
        n0p_out  <= n0p;
        rt_valid <= 1'b0;
      end else if (shift_en) begin
        cnt <= cnt + CNT_W'(1);
        if (last_beat) begin
          rt_valid <= 1'b1;
        end
      end
    end
  end

  word_shift_deser #(
    .DATA_WIDTH  (DATA_WIDTH),
    .DATA_LENGTH (DATA_LENGTH)
  ) u_r_deser (
    .clk      (clk),
    .reset    (reset),
    .clr      (clr),
    .shift_en (shift_en),
    .word_in  (r_word),
    .data_out (r_out)
  );

  word_shift_deser #(
    .DATA_WIDTH  (DATA_WIDTH),
    .DATA_LENGTH (DATA_LENGTH)
  ) u_t_deser (
    .clk      (clk),
    .reset    (reset),
    .clr      (clr),
    .shift_en (shift_en),
    .word_in  (t_word),
    .data_out (t_out)
  );

endmodule

// File: tb/tb_secondary_input_receiver.sv
// Bench for secondary_input_receiver: queue-based transfer model checked
// every cycle, plus hand-computed literal expectations per scenario.
module tb_secondary_input_receiver;

  localparam int DW    = 32;
  localparam int DL    = 1024;
  localparam int WORDS = DL / DW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start_transfer = 1'b0;
  logic          word_valid = 1'b0;
  logic [DW-1:0] r_word = '0;
  logic [DW-1:0] t_word = '0;
  logic [DW-1:0] n0p = '0;
  logic [DL-1:0] r_out;
  logic [DL-1:0] t_out;
  logic [DW-1:0] n0p_out;
  logic          busy;
  logic          rt_valid;
  logic          done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  secondary_input_receiver #(
    .DATA_WIDTH  (DW),
    .DATA_LENGTH (DL)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start_transfer (start_transfer),
    .word_valid     (word_valid),
    .r_word         (r_word),
    .t_word         (t_word),
    .n0p            (n0p),
    .r_out          (r_out),
    .t_out          (t_out),
    .n0p_out        (n0p_out),
    .busy           (busy),
    .rt_valid       (rt_valid),
    .done           (done)
  );

  // Model: a transfer is a list of accepted words; the operand is that list
  // laid out MSW first. A transfer completes once the list holds WORDS entries.
  logic [DW-1:0] qr[$];
  logic [DW-1:0] qt[$];
  bit            m_active   = 0;
  bit            m_complete = 0;
  bit            m_done     = 0;
  bit            m_prev_st  = 0;
  logic [DW-1:0] m_n0p      = '0;

  function automatic logic [DL-1:0] pack_r();
    logic [DL-1:0] v = '0;
    for (int i = 0; i < qr.size(); i++) v[(qr.size()-1-i)*DW +: DW] = qr[i];
    return v;
  endfunction

  function automatic logic [DL-1:0] pack_t();
    logic [DL-1:0] v = '0;
    for (int i = 0; i < qt.size(); i++) v[(qt.size()-1-i)*DW +: DW] = qt[i];
    return v;
  endfunction

  always @(posedge clk) begin
    bit rise;
    if (reset) begin
      qr.delete(); qt.delete();
      m_active = 0; m_complete = 0; m_done = 0; m_prev_st = 0; m_n0p = '0;
    end else begin
      rise      = start_transfer && !m_prev_st;
      m_prev_st = start_transfer;
      m_done    = 0;
      if (rise) begin
        qr.delete(); qt.delete();
        m_n0p = n0p; m_complete = 0; m_active = 1;
      end else if (m_active && word_valid) begin
        qr.push_back(r_word);
        qt.push_back(t_word);
        if (qr.size() == WORDS) begin
          m_active = 0; m_complete = 1; m_done = 1;
        end
      end
    end
  end

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic check32(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic check_wide(input string name, input logic [DL-1:0] act, input logic [DL-1:0] exp);
    checks++;
    if (act !== exp) begin
      int idx = 0;
      errors++;
      for (int i = WORDS - 1; i >= 0; i--)
        if (act[i*DW +: DW] !== exp[i*DW +: DW]) begin idx = i; break; end
      $display("FAIL %s @%0t: word %0d got %h expected %h", name, $time, idx,
               act[idx*DW +: DW], exp[idx*DW +: DW]);
    end
  endtask

  bit chk_en    = 0;
  bit prev_done = 0;
  int done_seen = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      check_wide("r_out", r_out, pack_r());
      check_wide("t_out", t_out, pack_t());
      check32("n0p_out", n0p_out, m_n0p);
      check_bit("busy", busy, m_active);
      check_bit("rt_valid", rt_valid, m_complete);
      check_bit("done", done, m_done);
      check_bit("done_not_twice", done && prev_done, 1'b0);
      check_bit("rt_valid_while_busy", rt_valid && busy, 1'b0);
      if (done === 1'b1) done_seen++;
      prev_done = (done === 1'b1);
    end
  end

  task automatic cyc(input logic rst, input logic st, input logic wv,
                     input logic [DW-1:0] rw, input logic [DW-1:0] tw,
                     input logic [DW-1:0] np);
    @(negedge clk);
    reset = rst; start_transfer = st; word_valid = wv;
    r_word = rw; t_word = tw; n0p = np;
  endtask

  task automatic idle(input logic st, input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, st, 1'b0, '0, '0, 32'h0);
  endtask

  // Opens a transfer: start low for a cycle, then the rising edge.
  task automatic open_xfer(input logic [DW-1:0] np);
    cyc(1'b0, 1'b0, 1'b0, '0, '0, np);
    cyc(1'b0, 1'b1, 1'b0, '0, '0, np);
  endtask

  task automatic beats(input int n, input logic [DW-1:0] base);
    for (int k = 0; k < n; k++)
      cyc(1'b0, 1'b1, 1'b1, base + DW'(k), ~(base + DW'(k)), 32'h0);
  endtask

  initial begin
    int d0;
    logic [DL-1:0] zero_w;
    zero_w = '0;
    cyc(1'b1, 1'b0, 1'b0, '0, '0, '0);
    cyc(1'b1, 1'b0, 1'b0, '0, '0, '0);
    chk_en = 1;
    cyc(1'b0, 1'b0, 1'b0, '0, '0, '0);
    check_wide("reset_r_out", r_out, zero_w);
    check_bit("reset_busy", busy, 1'b0);
    check_bit("reset_rt_valid", rt_valid, 1'b0);
    check_bit("reset_done", done, 1'b0);

    // 1: 32 back-to-back beats
    d0 = done_seen;
    open_xfer(32'hA5A5A5A5);
    beats(32, 32'd1);
    idle(1'b1, 1);
    check_bit("t1_done_pulse", done, 1'b1);
    idle(1'b1, 2);
    check32("t1_r_msw", r_out[DL-1 -: DW], 32'h00000001);
    check32("t1_r_lsw", r_out[DW-1:0], 32'h00000020);
    check32("t1_t_msw", t_out[DL-1 -: DW], 32'hFFFFFFFE);
    check32("t1_t_lsw", t_out[DW-1:0], 32'hFFFFFFDF);
    check32("t1_n0p", n0p_out, 32'hA5A5A5A5);
    check32("t1_done_count", 32'(done_seen - d0), 32'd1);

    // 2: trailing 33rd beat is discarded
    open_xfer(32'h0BADF00D);
    beats(32, 32'd1);
    cyc(1'b0, 1'b1, 1'b1, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0);
    idle(1'b1, 2);
    check32("t2_r_lsw", r_out[DW-1:0], 32'h00000020);
    check_bit("t2_rt_valid", rt_valid, 1'b1);

    // 3: beats on alternate cycles only
    d0 = done_seen;
    open_xfer(32'h01010101);
    for (int k = 0; k < 64; k++) begin
      if (k % 2 == 1) cyc(1'b0, 1'b1, 1'b1, DW'(k/2 + 1), ~DW'(k/2 + 1), 32'h0);
      else            cyc(1'b0, 1'b1, 1'b0, 32'hCAFE0000, 32'hCAFE0000, 32'h0);
    end
    idle(1'b1, 3);
    check32("t3_r_msw", r_out[DL-1 -: DW], 32'h00000001);
    check32("t3_r_lsw", r_out[DW-1:0], 32'h00000020);
    check32("t3_done_count", 32'(done_seen - d0), 32'd1);

    // 4: abort after 10 beats, relatch n0p, then complete
    d0 = done_seen;
    open_xfer(32'h11111111);
    beats(10, 32'h500);
    cyc(1'b0, 1'b0, 1'b0, '0, '0, 32'h12345678);
    cyc(1'b0, 1'b1, 1'b0, '0, '0, 32'h12345678);
    idle(1'b1, 1);
    check32("t4_n0p", n0p_out, 32'h12345678);
    check_bit("t4_busy", busy, 1'b1);
    check32("t4_abort_cleared", r_out[DW-1:0], 32'h0);
    check32("t4_no_done", 32'(done_seen - d0), 32'd0);
    beats(32, 32'h700);
    idle(1'b1, 3);
    check32("t4_r_msw", r_out[DL-1 -: DW], 32'h00000700);
    check32("t4_r_lsw", r_out[DW-1:0], 32'h0000071F);
    check32("t4_done_count", 32'(done_seen - d0), 32'd1);

    // 5: reset mid-transfer
    open_xfer(32'h22222222);
    beats(20, 32'h900);
    cyc(1'b1, 1'b1, 1'b1, 32'h99999999, 32'h99999999, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, '0, '0, 32'h0);
    check_wide("t5_r_zero", r_out, zero_w);
    check_wide("t5_t_zero", t_out, zero_w);
    check32("t5_n0p_zero", n0p_out, 32'h0);
    check_bit("t5_busy_zero", busy, 1'b0);
    check_bit("t5_rt_valid_zero", rt_valid, 1'b0);
    d0 = done_seen;
    open_xfer(32'h33333333);
    beats(32, 32'hA00);
    idle(1'b1, 3);
    check32("t5_r_lsw", r_out[DW-1:0], 32'h00000A1F);
    check32("t5_done_count", 32'(done_seen - d0), 32'd1);

    // 6: word on the start edge cycle is not captured
    cyc(1'b0, 1'b0, 1'b0, '0, '0, 32'h44444444);
    cyc(1'b0, 1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h44444444);
    beats(32, 32'h100);
    idle(1'b1, 3);
    check32("t6_r_msw", r_out[DL-1 -: DW], 32'h00000100);
    check32("t6_r_lsw", r_out[DW-1:0], 32'h0000011F);
    check32("t6_n0p", n0p_out, 32'h44444444);

    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
